// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light front-end and controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package traffic_pkg;

  localparam int STATE_W = 2;

  // Start/stop sequencer states; encoding 3 is unused and recovers to OFF.
  typedef enum logic [STATE_W-1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } seq_state_t;

  // Light-state encodings used by the downstream light controller.
  typedef enum logic [1:0] {
    LT_RED    = 2'd0,
    LT_GREEN  = 2'd1,
    LT_YELLOW = 2'd2
  } light_t;

endpackage

// File: rtl/traffic_start_ctrl_if.sv
// Button input and sequencer outputs of the start front-end, bundled.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or single-cycle pulses.
interface traffic_start_ctrl_if;
  import traffic_pkg::*;

  logic               in_btn;
  logic               o_srt;
  logic               o_tl_rst;
  logic               o_tick;
  logic               o_arm;
  logic               o_btn_db;
  logic [STATE_W-1:0] o_state;

  // Front-end side: consumes the raw button, drives the controls.
  modport slave (
    input  in_btn,
    output o_srt, o_tl_rst, o_tick, o_arm, o_btn_db, o_state
  );

  // Environment side: drives the button, observes the controls.
  modport master (
    output in_btn,
    input  o_srt, o_tl_rst, o_tick, o_arm, o_btn_db, o_state
  );

endinterface

// File: rtl/tl_debounce.sv
// Button synchroniser, debouncer and press-edge detector.
// Latency: db follows a clean raw change on the (2+DEB_CYCLES)th edge; press is combinational from db.
// Backpressure: none; glitches shorter than DEB_CYCLES stable cycles are dropped.
module tl_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam int             DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]  DMAX = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db_d;
  logic [DW-1:0] dcnt;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from db for DEB_CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db   <= 1'b0;
      dcnt <= '0;
    end else if (sync2 != db) begin
      if (dcnt == DMAX) begin
        db   <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end else begin
      dcnt <= '0;
    end
  end

  // Delayed copy of db for rising-edge detection; releases are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_d <= 1'b0;
    else        db_d <= db;
  end

  assign press = db & ~db_d;

endmodule

// File: rtl/traffic_start_ctrl.sv
// Start/stop front-end: debounced button drives an OFF/ARM/RUN sequencer and a seconds-tick prescaler.
// Latency: ARM one edge after a debounced press; first tick TICK_DIV cycles after ARM entry; RUN after ARM_TICKS ticks.
// Backpressure: none; the light controller must accept o_srt/o_tl_rst/o_tick as presented.
module traffic_start_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 16,
  parameter int ARM_TICKS  = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  traffic_start_ctrl_if.slave  bus
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PPRE = PW'(TICK_DIV - 2);
  localparam int            AW   = $clog2(ARM_TICKS + 1);
  localparam logic [AW-1:0] AMAX = AW'(ARM_TICKS - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic          db;
  logic          press;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [AW-1:0] acnt;
  logic          tl_rst;

  tl_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .raw   (bus.in_btn),
    .db    (db),
    .press (press)
  );

  // Sequencer state register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= ST_OFF;
    else           state <= state_nxt;
  end

  // Next state; a press in ARM wins over the final arming tick.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF: if (press) state_nxt = ST_ARM;
      ST_ARM: begin
        if (press)                     state_nxt = ST_OFF;
        else if (tick && acnt == AMAX) state_nxt = ST_RUN;
      end
      ST_RUN: if (press) state_nxt = ST_OFF;
      default: state_nxt = ST_OFF;
    endcase
  end

  // Prescaler: parked at 0 in OFF and on the edge into OFF, so ARM always starts a fresh period.
  // The tick flop is loaded one count early so o_tick is high exactly while pcnt == TICK_DIV-1.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (state == ST_OFF || state_nxt == ST_OFF) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
      tick <= (pcnt == PPRE);
    end
  end

  // Count ticks spent arming; held clear outside ARM so each entry starts from 0.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)           acnt <= '0;
    else if (state != ST_ARM) acnt <= '0;
    else if (tick)           acnt <= acnt + 1'b1;
  end

  // Controller reset pulse for the first OFF cycle after leaving RUN; cancel from ARM does not pulse.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) tl_rst <= 1'b0;
    else           tl_rst <= (state == ST_RUN) && (state_nxt == ST_OFF);
  end

  assign bus.o_srt    = (state == ST_RUN);
  assign bus.o_arm    = (state == ST_ARM);
  assign bus.o_state  = state;
  assign bus.o_tick   = tick;
  assign bus.o_tl_rst = tl_rst;
  assign bus.o_btn_db = db;

endmodule
